// File: rtl/clk_aux_sel_ctrl.sv
// clk_aux_sel_ctrl
//   Sequences a safe switchover of the board clock mux select (SEL_CLK_AUX)
//   from a raw slide switch. The switch is synchronised and debounced. Each
//   change of the accepted request is wrapped in a hold window. Downstream
//   counters freeze during that window, and the select flips in its middle.
//   A free-running heartbeat drives an LED.
//
//   Optional build macro: CLK_SEL_WATCHDOG_EN
//     defined   : aux_tgl_i is watched for edges. A silent aux clock drops
//                 aux_ok_o. That forces a fallback to the main clock and
//                 sets the sticky err_o.
//     undefined : no watchdog. aux_ok_o is held high from the first cycle
//                 after reset. err_o stays low.
module clk_aux_sel_ctrl #(
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned WD_CYCLES     = 4096,
  parameter int unsigned HB_BITS       = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_sel_i,
  input  logic aux_tgl_i,
  output logic sel_clk_aux_o,
  output logic hold_o,
  output logic busy_o,
  output logic aux_ok_o,
  output logic err_o,
  output logic led_hb_o
);

  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SEQ_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

`ifdef CLK_SEL_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic sw_s1_q, sw_s2_q;

  // Two-flop synchroniser for the raw switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= 1'b0;
      sw_s2_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_sel_i;
      sw_s2_q <= sw_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             req_q, req_d;
  logic             sw_chg;
  logic             deb_done;

  // The synced value is about to change when the first stage differs from
  // the second. Restarting on that edge makes the count equal the number of
  // cycles the synced value has been stable.
  assign sw_chg   = sw_s1_q ^ sw_s2_q;
  assign deb_done = (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));

  // Stability counter and accepted-request update
  always_comb begin
    deb_cnt_d = deb_cnt_q + DEB_W'(1);
    req_d     = req_q;
    if (sw_chg || deb_done) begin
      deb_cnt_d = '0;
    end
    if (deb_done) begin
      req_d = sw_s2_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      req_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      req_q     <= req_d;
    end
  end

  // ---------------------------------------------------------------------
  // Aux clock liveness
  // ---------------------------------------------------------------------
  logic aux_ok_q, aux_ok_d;

`ifdef CLK_SEL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

  logic            tgl_s1_q, tgl_s2_q, tgl_s3_q;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            tgl_edge;
  logic            wd_done;

  // Synchroniser plus one delay stage for edge detection on the aux toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_s1_q <= 1'b0;
      tgl_s2_q <= 1'b0;
      tgl_s3_q <= 1'b0;
    end else begin
      tgl_s1_q <= aux_tgl_i;
      tgl_s2_q <= tgl_s1_q;
      tgl_s3_q <= tgl_s2_q;
    end
  end

  assign tgl_edge = tgl_s2_q ^ tgl_s3_q;
  assign wd_done  = (wd_cnt_q == WD_W'(WD_CYCLES - 1));

  // Any toggle edge revives the aux clock. A full silent window kills it.
  always_comb begin
    wd_cnt_d = wd_cnt_q + WD_W'(1);
    aux_ok_d = aux_ok_q;
    if (tgl_edge || wd_done) begin
      wd_cnt_d = '0;
    end
    if (tgl_edge) begin
      aux_ok_d = 1'b1;
    end else if (wd_done) begin
      aux_ok_d = 1'b0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  // Without a watchdog the aux clock is assumed alive. The toggle input is
  // folded in only so that it is not left dangling; it has no effect.
  always_comb begin
    aux_ok_d = 1'b1 | aux_tgl_i;
  end
`endif

  // Liveness flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_ok_q <= 1'b0;
    end else begin
      aux_ok_q <= aux_ok_d;
    end
  end

  // ---------------------------------------------------------------------
  // Switchover sequencer
  // ---------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             tgt_q, tgt_d;
  logic             sel_q, sel_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             fallback;

  // A dead aux clock while it is selected forces a return to main, whatever
  // the switch says.
  assign fallback = WD_EN & sel_q & ~aux_ok_q;

  // Next-state logic. The select is registered on the edge that leaves HOLD.
  // As a result it is stable throughout SWITCH and SETTLE. The target is
  // frozen at HOLD entry, so a request change mid-sequence waits for IDLE.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    tgt_d     = tgt_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    err_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seq_cnt_d = '0;
        if (fallback) begin
          state_d = ST_HOLD;
          tgt_d   = 1'b0;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          err_set = 1'b1;
        end else if (req_q != sel_q) begin
          if (!req_q || aux_ok_q) begin
            state_d = ST_HOLD;
            tgt_d   = req_q;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (seq_cnt_q == SEQ_W'(GUARD_CYCLES - 1)) begin
          seq_cnt_d = '0;
          state_d   = ST_SWITCH;
          sel_d     = tgt_q;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      ST_SWITCH: begin
        seq_cnt_d = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (seq_cnt_q == SEQ_W'(SETTLE_CYCLES - 1)) begin
          seq_cnt_d = '0;
          state_d   = ST_IDLE;
          hold_d    = 1'b0;
          busy_d    = 1'b0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      default: begin
        seq_cnt_d = '0;
        state_d   = ST_IDLE;
        hold_d    = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    err_d = err_q | (WD_EN & err_set);
  end

  // Sequencer registers; reset returns to IDLE on the main clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seq_cnt_q <= '0;
      tgt_q     <= 1'b0;
      sel_q     <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      tgt_q     <= tgt_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Heartbeat
  // ---------------------------------------------------------------------
  logic [HB_BITS-1:0] hb_q;

  // Free-running heartbeat; deliberately independent of hold_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_q + HB_BITS'(1);
    end
  end

  assign sel_clk_aux_o = sel_q;
  assign hold_o        = hold_q;
  assign busy_o        = busy_q;
  assign aux_ok_o      = aux_ok_q;
  assign err_o         = err_q;
  assign led_hb_o      = hb_q[HB_BITS-1];

endmodule

// File: tb/tb_clk_aux_sel_ctrl.sv
// Directed bench for clk_aux_sel_ctrl with DEB=8, GUARD=4, SETTLE=8, WD=32, HB=4.
// Ex = x-th rising edge after the input change (or after reset release).
module tb_clk_aux_sel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_sel = 1'b0;
  logic aux_tgl = 1'b0;
  logic bg_tgl = 1'b0;
  logic sel, hold, busy, aux_ok, err, led;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int hc;
  int glitch;
  logic sel_e14, sel_e15;

  always #5 clk = ~clk;

  clk_aux_sel_ctrl #(
    .DEB_CYCLES   (8),
    .GUARD_CYCLES (4),
    .SETTLE_CYCLES(8),
    .WD_CYCLES    (32),
    .HB_BITS      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_sel_i     (sw_sel),
    .aux_tgl_i    (aux_tgl),
    .sel_clk_aux_o(sel),
    .hold_o       (hold),
    .busy_o       (busy),
    .aux_ok_o     (aux_ok),
    .err_o        (err),
    .led_hb_o     (led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  function automatic logic hb_exp(input int c);
    return ((c % 16) >= 8) ? 1'b1 : 1'b0;
  endfunction

  // Keeps the aux toggle alive in the default-flow steps of a watchdog build
  initial begin
    #3;
    forever begin
      #50;
      if (bg_tgl) aux_tgl = ~aux_tgl;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("rst_sel", sel, 1'b0);
    check("rst_hold", hold, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_auxok", aux_ok, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_led", led, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
`ifdef CLK_SEL_WATCHDOG_EN
    bg_tgl = 1'b1;
`endif

    // ---------------- heartbeat ----------------
    tick(1);
`ifndef CLK_SEL_WATCHDOG_EN
    check("auxok_after_rel", aux_ok, 1'b1);
`endif
    tick(6);
    check("hb_c7", led, 1'b0);
    tick(1);
    check("hb_c8", led, 1'b1);
    tick(7);
    check("hb_c15", led, 1'b1);
    tick(1);
    check("hb_c16", led, 1'b0);

    // ---------------- debounce: bouncing switch ----------------
    for (int i = 0; i < 10; i++) begin
      sw_sel = ~sw_sel;
      tick(5);
      check($sformatf("bounce_hold_%0d", i), hold, 1'b0);
      check($sformatf("bounce_sel_%0d", i), sel, 1'b0);
    end
    tick(12);
    check("bounce_end_hold", hold, 1'b0);

    // ---------------- request dropped during HOLD ----------------
    sw_sel = 1'b1;
    tick(10);
    check("mid_e10_hold", hold, 1'b0);
    tick(1);
    check("mid_e11_hold", hold, 1'b1);
    check("mid_e11_busy", busy, 1'b1);
    sw_sel = 1'b0;
    tick(3);
    check("mid_e14_sel", sel, 1'b0);
    tick(1);
    check("mid_e15_sel", sel, 1'b1);
    glitch = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (sel !== 1'b1) glitch++;
    end
    check("mid_settle_glitch", glitch, 0);
    tick(1);
    check("mid_e24_hold", hold, 1'b0);
    check("mid_e24_busy", busy, 1'b0);
    check("mid_e24_sel", sel, 1'b1);
    tick(1);
    check("mid_e25_hold", hold, 1'b1);
    tick(3);
    check("mid_e28_sel", sel, 1'b1);
    tick(1);
    check("mid_e29_sel", sel, 1'b0);
    tick(8);
    check("mid_e37_hold", hold, 1'b1);
    tick(1);
    check("mid_e38_hold", hold, 1'b0);
    check("mid_e38_sel", sel, 1'b0);

    // ---------------- full switch to aux, hold width ----------------
    tick(5);
    sw_sel = 1'b1;
    tick(10);
    check("aux_e10_hold", hold, 1'b0);
    tick(1);
    hc = 0;
    sel_e14 = 1'bx;
    sel_e15 = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) sel_e14 = sel;
      if (i == 4) sel_e15 = sel;
      if (i == 6) check("aux_hb_in_hold", led, hb_exp(cyc));
      if (hold !== 1'b1) break;
      hc++;
      tick(1);
    end
    check("aux_hold_len", hc, 13);
    check("aux_e14_sel", sel_e14, 1'b0);
    check("aux_e15_sel", sel_e15, 1'b1);
    check("aux_end_busy", busy, 1'b0);
    check("aux_end_sel", sel, 1'b1);
    check("aux_hb_after", led, hb_exp(cyc));

    // ---------------- full switch back to main ----------------
    tick(5);
    sw_sel = 1'b0;
    tick(11);
    hc = 0;
    sel_e14 = 1'bx;
    sel_e15 = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) sel_e14 = sel;
      if (i == 4) sel_e15 = sel;
      if (hold !== 1'b1) break;
      hc++;
      tick(1);
    end
    check("main_hold_len", hc, 13);
    check("main_e14_sel", sel_e14, 1'b1);
    check("main_e15_sel", sel_e15, 1'b0);

    // ---------------- reset mid-SETTLE ----------------
    tick(5);
    sw_sel = 1'b1;
    tick(11);
    check("rs_e11_hold", hold, 1'b1);
    tick(8);
    check("rs_e19_sel", sel, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rs_async_sel", sel, 1'b0);
    check("rs_async_hold", hold, 1'b0);
    check("rs_async_busy", busy, 1'b0);
    check("rs_async_auxok", aux_ok, 1'b0);
    check("rs_async_led", led, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("rs_rel_hold", hold, 1'b0);
    check("rs_rel_sel", sel, 1'b0);
    tick(10);
    check("rs_e10_hold", hold, 1'b0);
    tick(1);
    check("rs_e11_hold", hold, 1'b1);
    check("rs_e11_sel", sel, 1'b0);
    tick(13);
    check("rs_e24_hold", hold, 1'b0);
    check("rs_e24_sel", sel, 1'b1);
`ifndef CLK_SEL_WATCHDOG_EN
    check("nowd_err", err, 1'b0);
    check("nowd_auxok", aux_ok, 1'b1);
`endif

`ifdef CLK_SEL_WATCHDOG_EN
    // ---------------- watchdog fallback ----------------
    bg_tgl = 1'b0;
    #2 rst = 1'b1;
    sw_sel = 1'b0;
    aux_tgl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
    aux_tgl = 1'b1;
    tick(2);
    check("wd_e2_auxok", aux_ok, 1'b0);
    tick(1);
    check("wd_e3_auxok", aux_ok, 1'b1);
    sw_sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      aux_tgl = ~aux_tgl;
      tick(5);
    end
    check("wd_alive_sel", sel, 1'b1);
    check("wd_alive_err", err, 1'b0);
    aux_tgl = ~aux_tgl;
    tick(34);
    check("wd_e34_auxok", aux_ok, 1'b1);
    tick(1);
    check("wd_e35_auxok", aux_ok, 1'b0);
    check("wd_e35_hold", hold, 1'b0);
    tick(1);
    check("wd_e36_hold", hold, 1'b1);
    check("wd_e36_err", err, 1'b1);
    tick(3);
    check("wd_e39_sel", sel, 1'b1);
    tick(1);
    check("wd_e40_sel", sel, 1'b0);
    tick(14);
    check("wd_dead_hold", hold, 1'b0);
    check("wd_dead_sel", sel, 1'b0);

    // ---------------- request while aux dead ----------------
    #2 rst = 1'b1;
    aux_tgl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("dead_rel_err", err, 1'b0);
    tick(10);
    check("dead_e10_err", err, 1'b0);
    tick(1);
    check("dead_e11_err", err, 1'b1);
    check("dead_e11_hold", hold, 1'b0);
    tick(5);
    check("dead_wait_sel", sel, 1'b0);
    aux_tgl = 1'b1;
    tick(3);
    check("dead_rev_auxok", aux_ok, 1'b1);
    check("dead_rev_hold0", hold, 1'b0);
    tick(1);
    check("dead_rev_hold1", hold, 1'b1);
    tick(4);
    check("dead_rev_sel", sel, 1'b1);
    check("dead_rev_err", err, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
